udma_adc_rx_cfg_seq: RTL and testbench

UDMA_ADC_RX_CFG_SEQ -- requirements
Module: udma_adc_rx_cfg_seq

---
 rtl/udma_adc_cfg_pkg.sv | 37 +++
 rtl/udma_cfg_poll_timer.sv | 40 ++++
 rtl/udma_adc_rx_cfg_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_udma_adc_rx_cfg_seq.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_adc_cfg_pkg.sv
// Shared register map, CFG bit layout and sequencer state encoding for the uDMA ADC RX cfg sequencer.
package udma_adc_cfg_pkg;

    localparam logic [4:0] REG_SADDR = 5'h00;
    localparam logic [4:0] REG_SIZE  = 5'h01;
    localparam logic [4:0] REG_CFG   = 5'h02;

    localparam int CFG_CONT_BIT  = 0;
    localparam int CFG_DSIZE_LSB = 1;
    localparam int CFG_DSIZE_MSB = 2;
    localparam int CFG_EN_BIT    = 4;
    localparam int CFG_CLR_BIT   = 5;
    localparam int CFG_PEND_BIT  = 5;

    localparam logic [31:0] CFG_CLR_WORD = 32'd1 << CFG_CLR_BIT;

    typedef enum logic [2:0] {
        IDLE,
        WR_SADDR,
        WR_SIZE,
        WR_CFG,
        POLL_WAIT,
        POLL_RD,
        WR_CLR,
        FINISH
    } cfg_state_e;

    function automatic logic [31:0] cfg_word(input logic [1:0] dsize, input logic cont);
        logic [31:0] w;
        w = '0;
        w[CFG_EN_BIT] = 1'b1;
        w[CFG_DSIZE_MSB:CFG_DSIZE_LSB] = dsize;
        w[CFG_CONT_BIT] = cont;
        return w;
    endfunction

endpackage

// File: rtl/udma_cfg_poll_timer.sv
// Saturating idle-cycle counter between status reads; only present when UDMA_ADC_CFG_POLL_EN is defined.
`ifdef UDMA_ADC_CFG_POLL_EN
module udma_cfg_poll_timer #(
    parameter int POLL_INTERVAL = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(POLL_INTERVAL + 1);
    localparam logic [CW-1:0] LAST = CW'(POLL_INTERVAL - 1);
    localparam logic [CW-1:0] MAX  = CW'(POLL_INTERVAL);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && count_q != MAX) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires in the last idle cycle so the read is issued right after it.
    assign expired_o = enable_i && (count_q >= LAST);

endmodule
`endif

// File: rtl/udma_adc_rx_cfg_seq.sv
// Programs a uDMA ADC RX channel over the cfg bus and optionally polls it to completion.
// Polling is built only when UDMA_ADC_CFG_POLL_EN is defined.
module udma_adc_rx_cfg_seq
    import udma_adc_cfg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int POLL_INTERVAL  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [L2_AWIDTH_NOAL-1:0] prog_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     prog_size_i,
    input  logic [1:0]                prog_datasize_i,
    input  logic                      prog_continuous_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      aborted_o,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    output logic [4:0]                cfg_addr_o,
    output logic [31:0]               cfg_data_o,
    input  logic                      cfg_ready_i,
    input  logic [31:0]               cfg_data_i
);

    cfg_state_e                state_q, state_d;
    logic                      valid_q, valid_d, rwn_q, rwn_d;
    logic [4:0]                addr_q, addr_d;
    logic [31:0]               data_q, data_d;
    logic                      busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic                      abort_pend_q, abort_pend_d;
    logic [L2_AWIDTH_NOAL-1:0] saddr_q, saddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [1:0]                dsize_q, dsize_d;
    logic                      cont_q, cont_d;
    logic                      xfer, abort_req;
    logic                      unused_cfg_data;

    assign unused_cfg_data = ^cfg_data_i;

`ifdef UDMA_ADC_CFG_POLL_EN
    logic poll_expired;

    udma_cfg_poll_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_poll_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != POLL_WAIT),
        .enable_i  (state_q == POLL_WAIT),
        .expired_o (poll_expired)
    );
`endif

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rwn_d        = rwn_q;
        addr_d       = addr_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        abort_pend_d = abort_pend_q;
        saddr_d      = saddr_q;
        size_d       = size_q;
        dsize_d      = dsize_q;
        cont_d       = cont_q;
        xfer         = valid_q && cfg_ready_i;
        abort_req    = abort_i || abort_pend_q;

        // An abort during a stalled access is remembered until that access completes.
        if (abort_i && busy_q && state_q != WR_CLR && state_q != FINISH) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (prog_size_i != '0) begin
                        saddr_d = prog_startaddr_i;
                        size_d  = prog_size_i;
                        dsize_d = prog_datasize_i;
                        cont_d  = prog_continuous_i;
                        busy_d  = 1'b1;
                        state_d = WR_SADDR;
                        valid_d = 1'b1;
                        rwn_d   = 1'b0;
                        addr_d  = REG_SADDR;
                        data_d  = 32'(prog_startaddr_i);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WR_SADDR: begin
                if (xfer) begin
                    abort_pend_d = 1'b0;
                    if (abort_req) begin
                        state_d = WR_CLR;
                        addr_d  = REG_CFG;
                        data_d  = CFG_CLR_WORD;
                    end else begin
                        state_d = WR_SIZE;
                        addr_d  = REG_SIZE;
                        data_d  = 32'(size_q);
                    end
                end
            end
            WR_SIZE: begin
                if (xfer) begin
                    abort_pend_d = 1'b0;
                    if (abort_req) begin
                        state_d = WR_CLR;
                        addr_d  = REG_CFG;
                        data_d  = CFG_CLR_WORD;
                    end else begin
                        state_d = WR_CFG;
                        addr_d  = REG_CFG;
                        data_d  = cfg_word(dsize_q, cont_q);
                    end
                end
            end
            WR_CFG: begin
                if (xfer) begin
                    abort_pend_d = 1'b0;
                    if (abort_req) begin
                        state_d = WR_CLR;
                        addr_d  = REG_CFG;
                        data_d  = CFG_CLR_WORD;
                    end
`ifdef UDMA_ADC_CFG_POLL_EN
                    else if (!cont_q) begin
                        state_d = POLL_WAIT;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                    end
`endif
                    else begin
                        state_d = FINISH;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef UDMA_ADC_CFG_POLL_EN
            POLL_WAIT: begin
                if (abort_req) begin
                    abort_pend_d = 1'b0;
                    state_d      = WR_CLR;
                    valid_d      = 1'b1;
                    rwn_d        = 1'b0;
                    addr_d       = REG_CFG;
                    data_d       = CFG_CLR_WORD;
                end else if (poll_expired) begin
                    state_d = POLL_RD;
                    valid_d = 1'b1;
                    rwn_d   = 1'b1;
                    addr_d  = REG_CFG;
                    data_d  = '0;
                end
            end
            POLL_RD: begin
                if (xfer) begin
                    abort_pend_d = 1'b0;
                    rwn_d        = 1'b0;
                    if (abort_req) begin
                        state_d = WR_CLR;
                        addr_d  = REG_CFG;
                        data_d  = CFG_CLR_WORD;
                    end else begin
                        valid_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        if (!cfg_data_i[CFG_EN_BIT] && !cfg_data_i[CFG_PEND_BIT]) begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = POLL_WAIT;
                        end
                    end
                end
            end
`endif
            WR_CLR: begin
                if (xfer) begin
                    state_d      = IDLE;
                    valid_d      = 1'b0;
                    addr_d       = '0;
                    data_d       = '0;
                    busy_d       = 1'b0;
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            rwn_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            saddr_q      <= '0;
            size_q       <= '0;
            dsize_q      <= '0;
            cont_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rwn_q        <= rwn_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            saddr_q      <= saddr_d;
            size_q       <= size_d;
            dsize_q      <= dsize_d;
            cont_q       <= cont_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign cfg_valid_o = valid_q;
    assign cfg_rwn_o   = rwn_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_data_o  = data_q;

endmodule

// File: tb/tb_udma_adc_rx_cfg_seq.sv
// Directed bench for udma_adc_rx_cfg_seq; polling scenarios are built when UDMA_ADC_CFG_POLL_EN is defined.
module tb_udma_adc_rx_cfg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [11:0] p_addr = '0;
    logic [15:0] p_size = '0;
    logic [1:0]  p_dsize = '0;
    logic        p_cont = 1'b0;
    logic        busy, done, aborted;
    logic        cfg_valid, cfg_rwn;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_ready = 1'b1;
    logic [31:0] cfg_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          l_rwn[$];
    logic [4:0]  l_addr[$];
    logic [31:0] l_data[$];
    int          l_cyc[$];
    int          done_cnt = 0, aborted_cnt = 0, done_cyc = 0;

    udma_adc_rx_cfg_seq dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .abort_i           (abort),
        .prog_startaddr_i  (p_addr),
        .prog_size_i       (p_size),
        .prog_datasize_i   (p_dsize),
        .prog_continuous_i (p_cont),
        .busy_o            (busy),
        .done_o            (done),
        .aborted_o         (aborted),
        .cfg_valid_o       (cfg_valid),
        .cfg_rwn_o         (cfg_rwn),
        .cfg_addr_o        (cfg_addr),
        .cfg_data_o        (cfg_wdata),
        .cfg_ready_i       (cfg_ready),
        .cfg_data_i        (cfg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus transaction log and completion-pulse counters.
    always @(negedge clk) begin
        if (cfg_valid && cfg_ready) begin
            l_rwn.push_back(cfg_rwn);
            l_addr.push_back(cfg_addr);
            l_data.push_back(cfg_wdata);
            l_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (aborted) aborted_cnt <= aborted_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] a, input logic [15:0] s, input logic [1:0] d, input logic c);
        p_addr = a; p_size = s; p_dsize = d; p_cont = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end();
        int d0, a0;
        d0 = done_cnt;
        a0 = aborted_cnt;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done_cnt != d0 || aborted_cnt != a0) break;
        end
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({cfg_valid, cfg_rwn, busy, done, aborted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {cfg_valid, cfg_rwn, busy, done, aborted});
        end
        checks++;
        if ({cfg_addr, cfg_wdata} !== 37'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr %0h data %0h expected 0/0", cfg_addr, cfg_wdata);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({cfg_valid, busy} !== 2'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 00", {cfg_valid, busy});
        end
    endtask

    task automatic test_abort_idle();
        int b, a0;
        b = l_addr.size();
        a0 = aborted_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (5) step();
        checks++;
        if (l_addr.size() - b !== 0 || aborted_cnt !== a0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got %0d txns %0d aborts busy %b expected 0 0 0",
                     l_addr.size() - b, aborted_cnt - a0, busy);
        end
    endtask

    task automatic test_main();
        int b, d0, n;
        b = l_addr.size();
        d0 = done_cnt;
        cfg_ready = 1'b1;
        cfg_rdata = 32'h10;
        do_start(12'h100, 16'd64, 2'd2, 1'b0);
        checks++;
        if ({busy, cfg_valid, cfg_addr} !== {2'b11, 5'h00}) begin
            errors++;
            $display("FAIL main_first_cycle: got busy/valid/addr %b%b/%0h expected 11/0", busy, cfg_valid, cfg_addr);
        end
`ifdef UDMA_ADC_CFG_POLL_EN
        for (int i = 0; i < 400; i++) begin
            step();
            if (l_addr.size() - b >= 4) cfg_rdata = 32'h20;
            if (l_addr.size() - b >= 5) cfg_rdata = 32'h0;
            if (done_cnt != d0) break;
        end
        step();
        n = l_addr.size() - b;
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL main_txn_count: got %0d expected 6", n);
        end
        if (n >= 6) begin
            for (int k = 3; k < 6; k++) begin
                checks++;
                if ({l_rwn[b+k], l_addr[b+k], l_data[b+k]} !== {1'b1, 5'h02, 32'h0}) begin
                    errors++;
                    $display("FAIL main_read%0d: got rwn %b addr %0h data %0h expected 1 2 0",
                             k - 3, l_rwn[b+k], l_addr[b+k], l_data[b+k]);
                end
                checks++;
                if (l_cyc[b+k] - l_cyc[b+k-1] !== 17) begin
                    errors++;
                    $display("FAIL main_read_spacing%0d: got %0d expected 17", k - 3, l_cyc[b+k] - l_cyc[b+k-1]);
                end
            end
        end
`else
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL main_txn_count: got %0d expected 3", n);
        end
`endif
        if (n >= 3) begin
            checks++;
            if ({l_rwn[b], l_addr[b], l_data[b]} !== {1'b0, 5'h00, 32'h100}) begin
                errors++;
                $display("FAIL main_wr_saddr: got %b %0h %0h expected 0 0 100", l_rwn[b], l_addr[b], l_data[b]);
            end
            checks++;
            if ({l_rwn[b+1], l_addr[b+1], l_data[b+1]} !== {1'b0, 5'h01, 32'h40}) begin
                errors++;
                $display("FAIL main_wr_size: got %b %0h %0h expected 0 1 40", l_rwn[b+1], l_addr[b+1], l_data[b+1]);
            end
            checks++;
            if ({l_rwn[b+2], l_addr[b+2], l_data[b+2]} !== {1'b0, 5'h02, 32'h14}) begin
                errors++;
                $display("FAIL main_wr_cfg: got %b %0h %0h expected 0 2 14", l_rwn[b+2], l_addr[b+2], l_data[b+2]);
            end
            checks++;
            if (done_cyc !== l_cyc[b+n-1] + 1) begin
                errors++;
                $display("FAIL main_done_latency: got cycle %0d expected %0d", done_cyc, l_cyc[b+n-1] + 1);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL main_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if ({busy, cfg_valid, cfg_addr, cfg_wdata} !== 39'h0) begin
            errors++;
            $display("FAIL main_idle_bus: got busy %b valid %b addr %0h data %0h expected all 0",
                     busy, cfg_valid, cfg_addr, cfg_wdata);
        end
    endtask

    task automatic test_stall();
        int b, n, wr_size;
        b = l_addr.size();
        cfg_ready = 1'b1;
        do_start(12'h2A5, 16'h1234, 2'd1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (cfg_valid && cfg_addr == 5'h01) break;
            step();
        end
        cfg_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({cfg_valid, cfg_rwn, cfg_addr, cfg_wdata} !== {1'b1, 1'b0, 5'h01, 32'h1234}) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid %b addr %0h data %0h expected 1 1 1234",
                         i, cfg_valid, cfg_addr, cfg_wdata);
            end
        end
        cfg_ready = 1'b1;
        wait_end();
        n = l_addr.size() - b;
        wr_size = 0;
        for (int k = 0; k < n; k++) if (l_addr[b+k] == 5'h01) wr_size++;
        checks++;
        if (n !== 3 || wr_size !== 1) begin
            errors++;
            $display("FAIL stall_counts: got %0d txns %0d size writes expected 3 1", n, wr_size);
        end
        if (n >= 3) begin
            checks++;
            if (l_data[b+2] !== 32'h13) begin
                errors++;
                $display("FAIL stall_cfg_word: got %0h expected 13", l_data[b+2]);
            end
        end
    endtask

    task automatic test_cont();
        int b, d0, n;
        b = l_addr.size();
        d0 = done_cnt;
        cfg_ready = 1'b1;
        do_start(12'h0FF, 16'd3, 2'd0, 1'b1);
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 3 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL cont_counts: got %0d txns %0d done expected 3 1", n, done_cnt - d0);
        end
        if (n >= 3) begin
            checks++;
            if ({l_rwn[b+2], l_addr[b+2], l_data[b+2]} !== {1'b0, 5'h02, 32'h11}) begin
                errors++;
                $display("FAIL cont_cfg: got %b %0h %0h expected 0 2 11", l_rwn[b+2], l_addr[b+2], l_data[b+2]);
            end
            checks++;
            if (done_cyc !== l_cyc[b+2] + 1) begin
                errors++;
                $display("FAIL cont_done_latency: got %0d expected %0d", done_cyc, l_cyc[b+2] + 1);
            end
        end
    endtask

    task automatic test_abort_stall();
        int b, d0, a0, n;
        b = l_addr.size();
        d0 = done_cnt;
        a0 = aborted_cnt;
        cfg_ready = 1'b0;
        do_start(12'h010, 16'd8, 2'd0, 1'b0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checks++;
        if ({cfg_valid, cfg_addr, cfg_wdata} !== {1'b1, 5'h00, 32'h10}) begin
            errors++;
            $display("FAIL abort_inflight_hold: got valid %b addr %0h data %0h expected 1 0 10",
                     cfg_valid, cfg_addr, cfg_wdata);
        end
        cfg_ready = 1'b1;
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 2 || aborted_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL abort_stall_counts: got %0d txns %0d aborted %0d done expected 2 1 0",
                     n, aborted_cnt - a0, done_cnt - d0);
        end
        if (n >= 2) begin
            checks++;
            if ({l_rwn[b+1], l_addr[b+1], l_data[b+1]} !== {1'b0, 5'h02, 32'h20}) begin
                errors++;
                $display("FAIL abort_stall_clr: got %b %0h %0h expected 0 2 20", l_rwn[b+1], l_addr[b+1], l_data[b+1]);
            end
        end
    endtask

    task automatic test_abort_priority();
        int b, d0, a0, n;
        b = l_addr.size();
        d0 = done_cnt;
        a0 = aborted_cnt;
        cfg_ready = 1'b1;
        do_start(12'h020, 16'd4, 2'd1, 1'b1);
        step();
        step();
        checks++;
        if ({cfg_valid, cfg_addr} !== {1'b1, 5'h02}) begin
            errors++;
            $display("FAIL prio_at_cfg: got valid %b addr %0h expected 1 2", cfg_valid, cfg_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 4 || aborted_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL prio_counts: got %0d txns %0d aborted %0d done expected 4 1 0",
                     n, aborted_cnt - a0, done_cnt - d0);
        end
        if (n >= 4) begin
            checks++;
            if ({l_addr[b+3], l_data[b+3]} !== {5'h02, 32'h20}) begin
                errors++;
                $display("FAIL prio_clr: got %0h %0h expected 2 20", l_addr[b+3], l_data[b+3]);
            end
        end
    endtask

`ifdef UDMA_ADC_CFG_POLL_EN
    task automatic test_abort_poll();
        int b, d0, a0, n;
        b = l_addr.size();
        d0 = done_cnt;
        a0 = aborted_cnt;
        cfg_ready = 1'b1;
        cfg_rdata = 32'h10;
        do_start(12'h100, 16'd64, 2'd2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (l_addr.size() - b >= 3) break;
            step();
        end
        repeat (5) step();
        checks++;
        if ({busy, cfg_valid} !== 2'b10) begin
            errors++;
            $display("FAIL poll_wait_state: got busy/valid %b expected 10", {busy, cfg_valid});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 4 || aborted_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL abort_poll_counts: got %0d txns %0d aborted %0d done expected 4 1 0",
                     n, aborted_cnt - a0, done_cnt - d0);
        end
        if (n >= 4) begin
            checks++;
            if ({l_rwn[b+3], l_addr[b+3], l_data[b+3]} !== {1'b0, 5'h02, 32'h20}) begin
                errors++;
                $display("FAIL abort_poll_clr: got %b %0h %0h expected 0 2 20", l_rwn[b+3], l_addr[b+3], l_data[b+3]);
            end
        end
    endtask
`endif

    task automatic test_zero_and_busy();
        int b, d0, n;
        b = l_addr.size();
        d0 = done_cnt;
        do_start(12'h123, 16'd0, 2'd1, 1'b0);
        checks++;
        if ({done, cfg_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done: got done/valid/busy %b expected 100", {done, cfg_valid, busy});
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width: got %b expected 0", done);
        end
        repeat (3) step();
        checks++;
        if (l_addr.size() - b !== 0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL zero_counts: got %0d txns %0d done expected 0 1", l_addr.size() - b, done_cnt - d0);
        end
        b = l_addr.size();
        d0 = done_cnt;
        cfg_ready = 1'b0;
        do_start(12'h0AA, 16'd7, 2'd3, 1'b1);
        step();
        do_start(12'h3FF, 16'd5, 2'd0, 1'b0);
        step();
        cfg_ready = 1'b1;
        wait_end();
        repeat (5) step();
        n = l_addr.size() - b;
        checks++;
        if (n !== 3 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL busy_ignore_counts: got %0d txns %0d done expected 3 1", n, done_cnt - d0);
        end
        if (n >= 3) begin
            checks++;
            if ({l_data[b], l_data[b+1], l_data[b+2]} !== {32'hAA, 32'h7, 32'h17}) begin
                errors++;
                $display("FAIL busy_ignore_data: got %0h %0h %0h expected aa 7 17", l_data[b], l_data[b+1], l_data[b+2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, d0, a0, n;
        b = l_addr.size();
        d0 = done_cnt;
        a0 = aborted_cnt;
        cfg_ready = 1'b0;
        do_start(12'h055, 16'd9, 2'd0, 1'b1);
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cfg_valid, cfg_rwn, cfg_addr, cfg_wdata, busy, done, aborted} !== 42'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid %b addr %0h data %0h busy %b expected all 0",
                     cfg_valid, cfg_addr, cfg_wdata, busy);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (l_addr.size() - b !== 0 || done_cnt - d0 !== 0 || aborted_cnt - a0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_pulses: got %0d txns %0d done %0d aborted expected 0 0 0",
                     l_addr.size() - b, done_cnt - d0, aborted_cnt - a0);
        end
        cfg_ready = 1'b1;
        do_start(12'h066, 16'd2, 2'd1, 1'b1);
        wait_end();
        n = l_addr.size() - b;
        checks++;
        if (n !== 3 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_restart: got %0d txns %0d done expected 3 1", n, done_cnt - d0);
        end
        if (n >= 3) begin
            checks++;
            if ({l_data[b], l_data[b+1], l_data[b+2]} !== {32'h66, 32'h2, 32'h13}) begin
                errors++;
                $display("FAIL reset_mid_data: got %0h %0h %0h expected 66 2 13", l_data[b], l_data[b+1], l_data[b+2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abort_idle();
        test_main();
        test_stall();
        test_cont();
        test_abort_stall();
        test_abort_priority();
`ifdef UDMA_ADC_CFG_POLL_EN
        test_abort_poll();
`endif
        test_zero_and_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
